// File: rtl/adc_spi_reader.sv
// SPI read master for the dual 14-bit ADC: pulses AD_CONV, clocks a 34-bit frame
// in on SPI_SCK and presents both samples with a one-clock valid strobe.
module adc_spi_reader #(
  parameter int HALF_DIV   = 2,
  parameter int FRAME_BITS = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        SPI_MISO,
  output logic        AD_CONV,
  output logic        SPI_SCK,
  output logic        busy,
  output logic [13:0] data_a,
  output logic [13:0] data_b,
  output logic        data_valid
);
  localparam int DIV_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int SAMPLE_W   = 14;
  localparam int A_MSB_SLOT = 2;
  localparam int B_MSB_SLOT = 18;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q;
  logic                conv_tick_q;
  logic [SAMPLE_W-1:0] samp_a_q, samp_a_d;
  logic [SAMPLE_W-1:0] samp_b_q, samp_b_d;
  logic                tick;
  logic                sck_rise;

  assign tick     = (div_q == DIV_W'(HALF_DIV - 1));
  assign sck_rise = (state_q == SHIFT) && tick && !SPI_SCK;

  always_comb begin
    div_d = '0;
    if ((state_q == CONV) || (state_q == SHIFT)) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  // Only the 28 sample slots are kept; the bus-idle slots never reach a register.
  for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_capture
    assign samp_a_d[SAMPLE_W-1-gi] = (sck_rise && (bit_q == BIT_W'(A_MSB_SLOT + gi)))
                                     ? SPI_MISO : samp_a_q[SAMPLE_W-1-gi];
    assign samp_b_d[SAMPLE_W-1-gi] = (sck_rise && (bit_q == BIT_W'(B_MSB_SLOT + gi)))
                                     ? SPI_MISO : samp_b_q[SAMPLE_W-1-gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      conv_tick_q <= 1'b0;
      samp_a_q    <= '0;
      samp_b_q    <= '0;
      AD_CONV     <= 1'b0;
      SPI_SCK     <= 1'b0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      data_a      <= '0;
      data_b      <= '0;
    end else begin
      div_q      <= div_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      data_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CONV;
            AD_CONV     <= 1'b1;
            busy        <= 1'b1;
            bit_q       <= '0;
            conv_tick_q <= 1'b0;
          end
        end
        CONV: begin
          // Conversion pulse spans two divider ticks.
          if (tick) begin
            conv_tick_q <= 1'b1;
            if (conv_tick_q) begin
              state_q     <= SHIFT;
              AD_CONV     <= 1'b0;
              conv_tick_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (tick) begin
            SPI_SCK <= !SPI_SCK;
            if (!SPI_SCK) begin
              bit_q <= bit_q + 1'b1;
            end else if (bit_q == BIT_W'(FRAME_BITS)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          data_a     <= samp_a_q;
          data_b     <= samp_b_q;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench: two readers (HALF_DIV=2 and 1) fed by a behavioural ADC
// that presents frame slot n before the n-th SPI_SCK rise of each frame.
module tb_adc_spi_reader;
  localparam int HD0 = 2;
  localparam int HD1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s   [2];
  logic        start_s [2];
  logic        miso_s  [2] = '{1'b1, 1'b1};
  logic        conv_s  [2];
  logic        sck_s   [2];
  logic        busy_s  [2];
  logic        valid_s [2];
  logic [13:0] da_s    [2];
  logic [13:0] db_s    [2];

  adc_spi_reader #(.HALF_DIV(HD0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .SPI_MISO(miso_s[0]),
    .AD_CONV(conv_s[0]), .SPI_SCK(sck_s[0]), .busy(busy_s[0]),
    .data_a(da_s[0]), .data_b(db_s[0]), .data_valid(valid_s[0])
  );

  adc_spi_reader #(.HALF_DIV(HD1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .SPI_MISO(miso_s[1]),
    .AD_CONV(conv_s[1]), .SPI_SCK(sck_s[1]), .busy(busy_s[1]),
    .data_a(da_s[1]), .data_b(db_s[1]), .data_valid(valid_s[1])
  );

  function automatic int hd(input int k);
    return (k == 0) ? HD0 : HD1;
  endfunction

  // Frame slot n carries: A MSB..LSB in slots 2..15, B MSB..LSB in 18..31, idle elsewhere.
  function automatic logic [33:0] mk_frame(input logic [13:0] a, input logic [13:0] b,
                                           input logic [33:0] idle);
    logic [33:0] f;
    f = idle;
    for (int i = 0; i < 14; i++) begin
      f[2 + i]  = a[13 - i];
      f[18 + i] = b[13 - i];
    end
    return f;
  endfunction

  // ADC model and bus monitor
  logic [33:0] slots     [2] = '{34'h0, 34'h0};
  int          rc        [2] = '{0, 0};
  int          rises_tot [2] = '{0, 0};
  int          conv_clks [2] = '{0, 0};
  int          valid_tot [2] = '{0, 0};
  int          gap_err   [2] = '{0, 0};
  int          last_rise [2] = '{0, 0};
  logic        sck_prev  [2] = '{1'b0, 1'b0};
  logic        conv_prev [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (conv_s[k] === 1'b1 && conv_prev[k] !== 1'b1) rc[k] = 0;
      if (conv_s[k] === 1'b1) conv_clks[k]++;
      if (valid_s[k] === 1'b1) valid_tot[k]++;
      if (sck_s[k] === 1'b1 && sck_prev[k] !== 1'b1) begin
        if (rc[k] > 0 && (cyc - last_rise[k]) != 2 * hd(k)) gap_err[k]++;
        last_rise[k] = cyc;
        rc[k]++;
        rises_tot[k]++;
      end
      sck_prev[k]  = sck_s[k];
      conv_prev[k] = conv_s[k];
      miso_s[k]    = (rc[k] < 34) ? slots[k][rc[k]] : 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int k, input int limit, output int at, output logic ok);
    at = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid_s[k] === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic run_frame(input int k, input logic [13:0] a, input logic [13:0] b,
                           input logic [33:0] idle, input string tag);
    int   e0, at, r0, c0, g0;
    logic ok;
    slots[k] = mk_frame(a, b, idle);
    @(negedge clk);
    start_s[k] = 1'b1;
    e0 = cyc + 1;
    r0 = rises_tot[k];
    c0 = conv_clks[k];
    g0 = gap_err[k];
    @(negedge clk);
    start_s[k] = 1'b0;
    chk({tag, ".busy_on"}, 32'(busy_s[k]), 32'd1);
    wait_valid(k, 80 * hd(k) + 20, at, ok);
    chk({tag, ".valid_seen"}, 32'(ok), 32'd1);
    chk({tag, ".latency"}, at - e0, 70 * hd(k) + 1);
    chk({tag, ".data_a"}, 32'(da_s[k]), 32'(a));
    chk({tag, ".data_b"}, 32'(db_s[k]), 32'(b));
    chk({tag, ".sck_rises"}, rises_tot[k] - r0, 32'd34);
    chk({tag, ".conv_clks"}, conv_clks[k] - c0, 2 * hd(k));
    chk({tag, ".sck_period"}, gap_err[k] - g0, 32'd0);
    @(negedge clk);
    chk({tag, ".valid_1clk"}, 32'(valid_s[k]), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy_s[k]), 32'd0);
  endtask

  initial begin
    int   e0, t1, t2, t3, v0;
    logic ok, seen_sck, seen_conv, seen_other;
    logic [13:0] ra, rb;
    logic [33:0] ri;

    rst_s   = '{1'b0, 1'b0};
    start_s = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d.conv", k), 32'(conv_s[k]), 32'd0);
      chk($sformatf("rst%0d.sck", k), 32'(sck_s[k]), 32'd0);
      chk($sformatf("rst%0d.busy", k), 32'(busy_s[k]), 32'd0);
      chk($sformatf("rst%0d.valid", k), 32'(valid_s[k]), 32'd0);
      chk($sformatf("rst%0d.data_a", k), 32'(da_s[k]), 32'd0);
      chk($sformatf("rst%0d.data_b", k), 32'(db_s[k]), 32'd0);
    end
    rst_s = '{1'b1, 1'b1};

    // Idle with start low
    seen_sck = 1'b0; seen_conv = 1'b0; seen_other = 1'b0;
    repeat (200) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        seen_sck   |= (sck_s[k] !== 1'b0);
        seen_conv  |= (conv_s[k] !== 1'b0);
        seen_other |= (busy_s[k] !== 1'b0) || (valid_s[k] !== 1'b0) ||
                      (da_s[k] !== 14'h0) || (db_s[k] !== 14'h0);
      end
    end
    chk("idle.sck", 32'(seen_sck), 32'd0);
    chk("idle.conv", 32'(seen_conv), 32'd0);
    chk("idle.outputs", 32'(seen_other), 32'd0);

    // Directed frames
    run_frame(0, 14'h2A5C, 14'h1FFF, '1, "basic");
    run_frame(0, 14'h3FFF, 14'h2000, '0, "neg_idle0");
    run_frame(0, 14'h3FFF, 14'h2000, '1, "neg_idle1");
    run_frame(0, 14'h0000, 14'h0000, '1, "zero_idle1");

    // Randomised frames on both instances
    for (int i = 0; i < 6; i++) begin
      ra = 14'($urandom);
      rb = 14'($urandom);
      ri = 34'({$urandom, $urandom});
      run_frame(i % 2, ra, rb, ri, $sformatf("rand%0d", i));
    end

    // start held high: three back-to-back frames
    slots[0] = mk_frame(14'h1234, 14'h0ABC, 34'({$urandom, $urandom}));
    @(negedge clk);
    start_s[0] = 1'b1;
    e0 = cyc + 1;
    v0 = valid_tot[0];
    wait_valid(0, 200, t1, ok);
    chk("b2b.first_seen", 32'(ok), 32'd1);
    chk("b2b.first_latency", t1 - e0, 70 * HD0 + 1);
    wait_valid(0, 200, t2, ok);
    chk("b2b.second_seen", 32'(ok), 32'd1);
    chk("b2b.spacing12", t2 - t1, 70 * HD0 + 2);
    repeat (5) @(negedge clk);
    start_s[0] = 1'b0;
    wait_valid(0, 200, t3, ok);
    chk("b2b.third_seen", 32'(ok), 32'd1);
    chk("b2b.spacing23", t3 - t2, 70 * HD0 + 2);
    chk("b2b.data_a", 32'(da_s[0]), 32'h1234);
    chk("b2b.data_b", 32'(db_s[0]), 32'h0ABC);
    repeat (200) @(negedge clk);
    chk("b2b.frame_count", valid_tot[0] - v0, 32'd3);

    // start pulses during SHIFT are ignored
    slots[0] = mk_frame(14'h0F0F, 14'h3333, '1);
    @(negedge clk);
    start_s[0] = 1'b1;
    e0 = cyc + 1;
    v0 = valid_tot[0];
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (40) @(negedge clk);
    repeat (3) begin
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (20) @(negedge clk);
    end
    wait_valid(0, 200, t1, ok);
    chk("ign.valid_seen", 32'(ok), 32'd1);
    chk("ign.latency", t1 - e0, 70 * HD0 + 1);
    chk("ign.data_a", 32'(da_s[0]), 32'h0F0F);
    repeat (200) @(negedge clk);
    chk("ign.frame_count", valid_tot[0] - v0, 32'd1);

    // Reset at the 20th SCK rise aborts the frame
    slots[0] = mk_frame(14'h2222, 14'h1111, '1);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rc[0] >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort.reached_rise20", 32'(ok), 32'd1);
    rst_s[0] = 1'b0;
    v0 = valid_tot[0];
    @(negedge clk);
    chk("abort.busy", 32'(busy_s[0]), 32'd0);
    chk("abort.sck", 32'(sck_s[0]), 32'd0);
    chk("abort.conv", 32'(conv_s[0]), 32'd0);
    chk("abort.data_a", 32'(da_s[0]), 32'd0);
    chk("abort.data_b", 32'(db_s[0]), 32'd0);
    rst_s[0] = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort.no_valid", valid_tot[0] - v0, 32'd0);
    run_frame(0, 14'($urandom), 14'($urandom), 34'({$urandom, $urandom}), "after_abort");

    // HALF_DIV=1 alternating pattern
    run_frame(1, 14'h1555, 14'h2AAA, 34'({$urandom, $urandom}), "hd1_alt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
